// File: rtl/clause_eval_sequencer.sv
// ---------------------------------------------------------------------------
// clause_eval_sequencer
//
// Purpose:
//   Scans the clause database in index order for one assignment snapshot.
//   For each clause it gathers the value/unassigned bit of every literal
//   slot from the variable assignment table. It hands those vectors to the
//   external partial_sat_evaluator and classifies each clause as satisfied,
//   conflicting, unit or undecided. A conflict ends the scan early. The
//   first unit clause in index order is latched as the implication result.
//
// Pipeline (start sampled at edge 0):
//   stage A : clause address issued    (cycle k+1 for clause k)
//   stage B : clause memory data valid (cycle k+2), gathered into eval_*
//   stage C : eval_* presented         (cycle k+3), classified at its end
//
// Ports:
//   clock, reset_n         clock, synchronous active-low reset
//   start, num_clauses     scan request and clause count (sampled together)
//   var_val, var_unassign  assignment table snapshot (stable while busy)
//   clause_rd_en/addr      clause memory read request
//   clause_rd_vars/mask/pole  clause memory data, one cycle after read
//   eval_unassign/val/mask/pole  registered vectors to the evaluator
//   eval_partial_sat       evaluator result for the current eval_* vectors
//   busy, done             scan in progress / one-cycle end-of-scan pulse
//   all_sat                every non-empty clause was satisfied
//   conflict, conflict_idx conflicting clause found and its index
//   unit_found, unit_var, unit_val  first unit clause's implication
// ---------------------------------------------------------------------------
module clause_eval_sequencer #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int NUM_VARS       = 64,
  parameter int VAR_IDX_W      = $clog2(NUM_VARS),
  parameter int NUM_CLAUSES    = 256,
  parameter int CLAUSE_IDX_W   = $clog2(NUM_CLAUSES)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [CLAUSE_IDX_W:0]               num_clauses,
  input  logic [NUM_VARS-1:0]                 var_val,
  input  logic [NUM_VARS-1:0]                 var_unassign,
  output logic                                clause_rd_en,
  output logic [CLAUSE_IDX_W-1:0]             clause_rd_addr,
  input  logic [VAR_PER_CLAUSE*VAR_IDX_W-1:0] clause_rd_vars,
  input  logic [VAR_PER_CLAUSE-1:0]           clause_rd_mask,
  input  logic [VAR_PER_CLAUSE-1:0]           clause_rd_pole,
  output logic [VAR_PER_CLAUSE-1:0]           eval_unassign,
  output logic [VAR_PER_CLAUSE-1:0]           eval_val,
  output logic [VAR_PER_CLAUSE-1:0]           eval_mask,
  output logic [VAR_PER_CLAUSE-1:0]           eval_pole,
  input  logic                                eval_partial_sat,
  output logic                                busy,
  output logic                                done,
  output logic                                all_sat,
  output logic                                conflict,
  output logic [CLAUSE_IDX_W-1:0]             conflict_idx,
  output logic                                unit_found,
  output logic [VAR_IDX_W-1:0]                unit_var,
  output logic                                unit_val
);

  localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FSM and stage A
  state_t                          r_state;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_rd_en;
  logic [CLAUSE_IDX_W-1:0]         r_rd_addr;
  logic [CLAUSE_IDX_W-1:0]         r_last_addr;

  // stage B (memory data valid) and stage C (eval vectors valid)
  logic                            r_b_valid;
  logic [CLAUSE_IDX_W-1:0]         r_b_idx;
  logic                            r_c_valid;
  logic [CLAUSE_IDX_W-1:0]         r_c_idx;
  logic [VAR_PER_CLAUSE*VAR_IDX_W-1:0] r_c_vars;
  logic [VAR_PER_CLAUSE-1:0]       r_eval_unassign;
  logic [VAR_PER_CLAUSE-1:0]       r_eval_val;
  logic [VAR_PER_CLAUSE-1:0]       r_eval_mask;
  logic [VAR_PER_CLAUSE-1:0]       r_eval_pole;

  // scan results
  logic                            r_all_sat;
  logic                            r_conflict;
  logic [CLAUSE_IDX_W-1:0]         r_conflict_idx;
  logic                            r_unit_found;
  logic [VAR_IDX_W-1:0]            r_unit_var;
  logic                            r_unit_val;

  // gather mux outputs
  logic [VAR_PER_CLAUSE-1:0]       w_gather_val;
  logic [VAR_PER_CLAUSE-1:0]       w_gather_unassign;

  // stage C classification
  logic [VAR_PER_CLAUSE-1:0]       w_c_open;
  logic [CNT_W-1:0]                w_u_cnt;
  logic [VAR_IDX_W-1:0]            w_unit_var;
  logic                            w_unit_pole;
  logic                            w_c_nonsat;
  logic                            w_c_conflict;
  logic                            w_c_unit;

  // Per-slot lookup into the assignment table. Empty slots are forced to
  // zero so the evaluator never sees stale bits from a don't-care index.
  for (genvar gi = 0; gi < VAR_PER_CLAUSE; gi++) begin : g_gather
    logic [VAR_IDX_W-1:0] w_idx;
    assign w_idx                 = clause_rd_vars[gi*VAR_IDX_W +: VAR_IDX_W];
    assign w_gather_val[gi]      = clause_rd_mask[gi] & var_val[w_idx];
    assign w_gather_unassign[gi] = clause_rd_mask[gi] & var_unassign[w_idx];
  end

  // Slots holding an unassigned literal. For a non-satisfied clause these
  // are the only literals that could still become true.
  assign w_c_open = r_eval_mask & r_eval_unassign;

  // Count open slots and remember which one; the remembered slot is only
  // meaningful when exactly one is open (unit clause).
  always_comb begin
    w_u_cnt     = '0;
    w_unit_var  = '0;
    w_unit_pole = 1'b0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (w_c_open[i]) begin
        w_u_cnt     = w_u_cnt + CNT_W'(1);
        w_unit_var  = r_c_vars[i*VAR_IDX_W +: VAR_IDX_W];
        w_unit_pole = r_eval_pole[i];
      end
    end
  end

  // Empty clauses (mask == 0) never count against the scan.
  assign w_c_nonsat   = r_c_valid & (|r_eval_mask) & ~eval_partial_sat;
  assign w_c_conflict = w_c_nonsat & (w_u_cnt == CNT_W'(0));
  assign w_c_unit     = w_c_nonsat & (w_u_cnt == CNT_W'(1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_rd_en         <= 1'b0;
      r_rd_addr       <= '0;
      r_last_addr     <= '0;
      r_b_valid       <= 1'b0;
      r_b_idx         <= '0;
      r_c_valid       <= 1'b0;
      r_c_idx         <= '0;
      r_c_vars        <= '0;
      r_eval_unassign <= '0;
      r_eval_val      <= '0;
      r_eval_mask     <= '0;
      r_eval_pole     <= '0;
      r_all_sat       <= 1'b0;
      r_conflict      <= 1'b0;
      r_conflict_idx  <= '0;
      r_unit_found    <= 1'b0;
      r_unit_var      <= '0;
      r_unit_val      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Pipeline advance: stage A -> B follows the read strobe, B -> C
      // captures the gathered vectors whenever memory data is valid.
      r_b_valid <= r_rd_en;
      r_b_idx   <= r_rd_addr;
      r_c_valid <= r_b_valid;
      r_c_idx   <= r_b_idx;
      if (r_b_valid) begin
        r_c_vars        <= clause_rd_vars;
        r_eval_unassign <= w_gather_unassign;
        r_eval_val      <= w_gather_val;
        r_eval_mask     <= clause_rd_mask;
        r_eval_pole     <= clause_rd_pole;
      end

      // Result accumulation from stage C.
      if (w_c_nonsat) begin
        r_all_sat <= 1'b0;
      end
      if (w_c_unit && !r_unit_found) begin
        r_unit_found <= 1'b1;
        r_unit_var   <= w_unit_var;
        r_unit_val   <= ~w_unit_pole;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy         <= 1'b1;
            r_all_sat      <= 1'b1;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_unit_found   <= 1'b0;
            r_unit_var     <= '0;
            r_unit_val     <= 1'b0;
            if (num_clauses == '0) begin
              // Nothing to scan: trivially satisfied, finish next cycle.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_rd_en     <= 1'b1;
              r_rd_addr   <= '0;
              // A full-depth count wraps to all-ones here, which is the
              // correct last index.
              r_last_addr <= num_clauses[CLAUSE_IDX_W-1:0] - CLAUSE_IDX_W'(1);
            end
          end
        end

        S_FETCH: begin
          if (r_rd_addr == r_last_addr) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + CLAUSE_IDX_W'(1);
          end
        end

        S_DRAIN: begin
          // Both downstream stages empty means the last clause has been
          // classified in the previous cycle.
          if (!r_b_valid && !r_c_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase

      // A conflict ends the scan at once and overrides the FSM update above:
      // stop issuing and throw away whatever is still in stages A/B.
      if (w_c_conflict) begin
        r_conflict     <= 1'b1;
        r_conflict_idx <= r_c_idx;
        r_state        <= S_DONE;
        r_done         <= 1'b1;
        r_rd_en        <= 1'b0;
        r_b_valid      <= 1'b0;
        r_c_valid      <= 1'b0;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign clause_rd_en   = r_rd_en;
  assign clause_rd_addr = r_rd_addr;
  assign eval_unassign  = r_eval_unassign;
  assign eval_val       = r_eval_val;
  assign eval_mask      = r_eval_mask;
  assign eval_pole      = r_eval_pole;
  assign all_sat        = r_all_sat;
  assign conflict       = r_conflict;
  assign conflict_idx   = r_conflict_idx;
  assign unit_found     = r_unit_found;
  assign unit_var       = r_unit_var;
  assign unit_val       = r_unit_val;

endmodule

// File: tb/tb_clause_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clause_eval_sequencer
//
// Testbench for clause_eval_sequencer. It provides a clause memory with a
// one-cycle registered read and a behavioural partial-SAT evaluator. A
// reference model classifies the clause list straight from the literal
// rules. Directed scenarios are followed by randomized scans, and each scan
// prints one line.
// ---------------------------------------------------------------------------
module tb_clause_eval_sequencer;

  localparam int VPC = 5;
  localparam int NV  = 64;
  localparam int VW  = 6;
  localparam int NC  = 256;
  localparam int CW  = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [CW:0]       num_clauses = '0;
  logic [NV-1:0]     var_val = '0;
  logic [NV-1:0]     var_unassign = '0;
  logic              clause_rd_en;
  logic [CW-1:0]     clause_rd_addr;
  logic [VPC*VW-1:0] clause_rd_vars = '0;
  logic [VPC-1:0]    clause_rd_mask = '0;
  logic [VPC-1:0]    clause_rd_pole = '0;
  logic [VPC-1:0]    eval_unassign, eval_val, eval_mask, eval_pole;
  logic              eval_partial_sat;
  logic              busy, done, all_sat, conflict, unit_found, unit_val;
  logic [CW-1:0]     conflict_idx;
  logic [VW-1:0]     unit_var;

  clause_eval_sequencer dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .num_clauses      (num_clauses),
    .var_val          (var_val),
    .var_unassign     (var_unassign),
    .clause_rd_en     (clause_rd_en),
    .clause_rd_addr   (clause_rd_addr),
    .clause_rd_vars   (clause_rd_vars),
    .clause_rd_mask   (clause_rd_mask),
    .clause_rd_pole   (clause_rd_pole),
    .eval_unassign    (eval_unassign),
    .eval_val         (eval_val),
    .eval_mask        (eval_mask),
    .eval_pole        (eval_pole),
    .eval_partial_sat (eval_partial_sat),
    .busy             (busy),
    .done             (done),
    .all_sat          (all_sat),
    .conflict         (conflict),
    .conflict_idx     (conflict_idx),
    .unit_found       (unit_found),
    .unit_var         (unit_var),
    .unit_val         (unit_val)
  );

  always #5 clock = ~clock;

  // Clause memory: registered read, data valid the cycle after the strobe.
  logic [VPC*VW-1:0] mem_vars [NC];
  logic [VPC-1:0]    mem_mask [NC];
  logic [VPC-1:0]    mem_pole [NC];

  always @(posedge clock) begin
    if (clause_rd_en) begin
      clause_rd_vars <= mem_vars[clause_rd_addr];
      clause_rd_mask <= mem_mask[clause_rd_addr];
      clause_rd_pole <= mem_pole[clause_rd_addr];
    end
  end

  // Partial-SAT evaluator: any present, assigned literal that is true.
  assign eval_partial_sat = |(eval_mask & ~eval_unassign & (eval_val ^ eval_pole));

  logic [48:0] all_outs;
  assign all_outs = {busy, done, clause_rd_en, all_sat, conflict, unit_found, unit_val,
                     eval_unassign, eval_val, eval_mask, eval_pole,
                     clause_rd_addr, conflict_idx, unit_var};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model results
  bit exp_all_sat, exp_conflict, exp_unit, exp_uval;
  int exp_cidx, exp_uvar, exp_done_cyc, exp_reads, n_class;

  task automatic model_scan(input int n);
    int n_true, n_open, open_slot;
    logic [VW-1:0] v;
    exp_all_sat = 1; exp_conflict = 0; exp_cidx = 0;
    exp_unit = 0; exp_uvar = 0; exp_uval = 0; n_class = n;
    for (int k = 0; k < n; k++) begin
      n_true = 0; n_open = 0; open_slot = 0;
      for (int s = 0; s < VPC; s++) begin
        if (mem_mask[k][s]) begin
          v = mem_vars[k][s*VW +: VW];
          if (var_unassign[v]) begin
            n_open++;
            open_slot = s;
          end else if (var_val[v] != mem_pole[k][s]) begin
            n_true++;
          end
        end
      end
      if (mem_mask[k] != 0 && n_true == 0) begin
        exp_all_sat = 0;
        if (n_open == 0) begin
          exp_conflict = 1;
          exp_cidx = k;
          n_class = k + 1;
          break;
        end
        if (n_open == 1 && !exp_unit) begin
          exp_unit = 1;
          exp_uvar = int'(mem_vars[k][open_slot*VW +: VW]);
          exp_uval = ~mem_pole[k][open_slot];
        end
      end
    end
    if (n == 0) exp_done_cyc = 1;
    else if (exp_conflict) exp_done_cyc = exp_cidx + 4;
    else exp_done_cyc = n + 4;
    if (exp_conflict) exp_reads = (n < exp_cidx + 3) ? n : exp_cidx + 3;
    else exp_reads = n;
  endtask

  // Expected evaluator vectors for clause k: {unassign, val, mask, pole}
  function automatic logic [19:0] exp_gather(input int k);
    logic [VPC-1:0] u, v;
    logic [VW-1:0] idx;
    u = '0; v = '0;
    for (int s = 0; s < VPC; s++) begin
      if (mem_mask[k][s]) begin
        idx = mem_vars[k][s*VW +: VW];
        u[s] = var_unassign[idx];
        v[s] = var_val[idx];
      end
    end
    return {u, v, mem_mask[k], mem_pole[k]};
  endfunction

  task automatic set_clause(input int k, input logic [4:0] m, input logic [4:0] p,
                            input int v0, input int v1, input int v2, input int v3, input int v4);
    mem_vars[k] = {VW'(v4), VW'(v3), VW'(v2), VW'(v1), VW'(v0)};
    mem_mask[k] = m;
    mem_pole[k] = p;
  endtask

  // One scan: start sampled at edge 0, then sample each cycle at negedge.
  task automatic run_scan(input int n, input bit poke_start);
    int reads;
    model_scan(n);
    @(negedge clock);
    num_clauses = (CW+1)'(n);
    start = 1'b1;
    @(posedge clock);
    reads = 0;
    for (int c = 1; c <= exp_done_cyc + 1; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (poke_start && c == 2) begin
        start = 1'b1;          // busy here: must be ignored
        num_clauses = '0;
      end
      if (clause_rd_en) begin
        check_val("rd_addr", clause_rd_addr, reads);
        reads++;
      end
      check_val("done", done, c == exp_done_cyc);
      if (c == 1 || c == exp_done_cyc + 1) check_val("busy", busy, c <= exp_done_cyc);
      if (c >= 3 && c - 3 < n_class)
        check_val("eval_vec", {eval_unassign, eval_val, eval_mask, eval_pole}, exp_gather(c - 3));
      if (c >= exp_done_cyc) begin
        check_val("all_sat", all_sat, exp_all_sat);
        check_val("conflict", conflict, exp_conflict);
        check_val("conflict_idx", conflict_idx, exp_cidx);
        check_val("unit_found", unit_found, exp_unit);
        check_val("unit_var", unit_var, exp_uvar);
        check_val("unit_val", unit_val, exp_uval);
      end
    end
    start = 1'b0;
    check_val("n_reads", reads, exp_reads);
    $display("scan n=%0d all_sat=%0d conflict=%0d@%0d unit=%0d var=%0d val=%0d done_cyc=%0d reads=%0d",
             n, exp_all_sat, exp_conflict, exp_cidx, exp_unit, exp_uvar, exp_uval, exp_done_cyc, reads);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < NC; k++) set_clause(k, 5'b0, 5'b0, 0, 0, 0, 0, 0);

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_val("reset_outs", all_outs, 49'd0);
    reset_n = 1'b1;

    // 1: three satisfied clauses, start pulsed while busy
    var_val = '0; var_unassign = '0; var_val[0] = 1'b1;
    for (int k = 0; k < 8; k++) set_clause(k, 5'b00001, 5'b00000, 0, 0, 0, 0, 0);
    run_scan(3, 1);
    check_val("t1_all_sat", all_sat, 1);

    // 2: conflict at clause 2
    var_val[1] = 1'b1; var_val[2] = 1'b1; var_val[3] = 1'b1;
    set_clause(2, 5'b00111, 5'b00111, 1, 2, 3, 0, 0);
    run_scan(5, 0);
    check_val("t2_conflict", conflict, 1);
    check_val("t2_conflict_idx", conflict_idx, 2);

    // 3: unit on var9 (negated literal) -> value 0
    set_clause(0, 5'b00011, 5'b00010, 5, 9, 0, 0, 0);
    var_val[5] = 1'b0; var_unassign[9] = 1'b1;
    run_scan(1, 0);
    check_val("t3_unit_var", unit_var, 9);
    check_val("t3_unit_val", unit_val, 0);
    check_val("t3_all_sat", all_sat, 0);

    // 4: units at 1 and 3, conflict at 5
    for (int k = 0; k < 8; k++) set_clause(k, 5'b00001, 5'b00000, 0, 0, 0, 0, 0);
    var_unassign[4] = 1'b1; var_unassign[7] = 1'b1;
    set_clause(1, 5'b00001, 5'b00000, 4, 0, 0, 0, 0);
    set_clause(3, 5'b00001, 5'b00001, 7, 0, 0, 0, 0);
    set_clause(5, 5'b00001, 5'b00001, 1, 0, 0, 0, 0);
    run_scan(8, 0);
    check_val("t4_unit_var", unit_var, 4);
    check_val("t4_conflict_idx", conflict_idx, 5);

    // 5: empty scan, then an empty clause mid-scan
    run_scan(0, 0);
    check_val("t5_all_sat_n0", all_sat, 1);
    for (int k = 0; k < 8; k++) set_clause(k, 5'b00001, 5'b00000, 0, 0, 0, 0, 0);
    set_clause(1, 5'b00000, 5'b10101, 9, 4, 7, 1, 2);
    run_scan(3, 0);
    check_val("t5_all_sat_mask0", all_sat, 1);

    // 6: reset at cycle 3 of an 8-clause scan
    @(negedge clock);
    num_clauses = 9'd8;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;        // cycle 1
    @(negedge clock);                      // cycle 2
    @(negedge clock); reset_n = 1'b0;      // cycle 3
    @(negedge clock);                      // cycle 4
    check_val("midscan_reset_outs", all_outs, 49'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check_val("post_reset_idle", {busy, done, clause_rd_en}, 3'b000);
    end
    $display("reset mid-scan: outputs cleared, no done");
    run_scan(8, 0);

    // 7: full-depth scan, every clause satisfied
    for (int k = 0; k < NC; k++) set_clause(k, 5'b00001, 5'b00000, 0, 0, 0, 0, 0);
    run_scan(256, 0);

    // 8: randomized scans
    for (int t = 0; t < 40; t++) begin
      var_val = {$urandom(), $urandom()};
      if (t % 2 == 0) var_unassign = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      else            var_unassign = {$urandom(), $urandom()} | {$urandom(), $urandom()};
      n = (t == 0) ? 1 : int'($urandom_range(2, 24));
      for (int k = 0; k < n; k++) begin
        mem_mask[k] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) mem_mask[k] = 5'b0;
        mem_pole[k] = 5'($urandom_range(0, 31));
        for (int s = 0; s < VPC; s++) mem_vars[k][s*VW +: VW] = VW'($urandom_range(0, 63));
      end
      run_scan(n, t % 3 == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clause_eval_sequencer.md
# clause_eval_sequencer

Drives the per-clause partial-SAT check across the whole clause database for one assignment snapshot. Walks clause memory in index order and gathers each clause's per-literal value/unassigned bits from the variable assignment table. Presents the gathered vectors to `partial_sat_evaluator` and classifies every clause as satisfied, conflicting, unit or undecided. Sits between the DPLL decision/propagation controller (which issues `start`) and `partial_sat_evaluator`, whose combinational `partial_sat` it consumes.

## Interface
- `VAR_PER_CLAUSE`, 5: literal slots per clause.
- `NUM_VARS`, 64: variables in assignment table.
- `VAR_IDX_W`, $clog2(NUM_VARS): variable index width.
- `NUM_CLAUSES`, 256: clause memory depth.
- `CLAUSE_IDX_W`, $clog2(NUM_CLAUSES): clause index width.

- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a scan; ignored while `busy`.
- `num_clauses`  in  CLAUSE_IDX_W+1  clauses to scan, sampled with `start`.
- `var_val`  in  NUM_VARS  assigned value per variable.
- `var_unassign`  in  NUM_VARS  1 = variable unassigned.
- `clause_rd_en`  out  1  clause memory read strobe.
- `clause_rd_addr`  out  CLAUSE_IDX_W  clause index.
- `clause_rd_vars`  in  VAR_PER_CLAUSE*VAR_IDX_W  slot i variable index at bits [i*VAR_IDX_W +: VAR_IDX_W]; valid 1 cycle after `clause_rd_en`.
- `clause_rd_mask`  in  VAR_PER_CLAUSE  1 = slot holds a literal.
- `clause_rd_pole`  in  VAR_PER_CLAUSE  1 = negated literal.
- `eval_unassign`, `eval_val`, `eval_mask`, `eval_pole`  out  VAR_PER_CLAUSE each  registered vectors to evaluator.
- `eval_partial_sat`  in  1  evaluator result for current eval vectors (combinational).
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at scan end.
- `all_sat`  out  1  every non-empty clause satisfied.
- `conflict`  out  1  a conflicting clause was found.
- `conflict_idx`  out  CLAUSE_IDX_W  index of that clause.
- `unit_found`  out  1  at least one unit clause seen.
- `unit_var`  out  VAR_IDX_W  implied variable of first unit clause.
- `unit_val`  out  1  value that satisfies it.

## Operation
- Literal i is true iff `mask[i] & ~unassign[i] & (val[i] ^ pole[i])`, matching the evaluator; `eval_partial_sat` is the OR of these.
- FSM: IDLE -> FETCH on `start` (and `num_clauses` != 0); FETCH issues one address per cycle, 0..num_clauses-1; FETCH -> DRAIN after last issue; DRAIN -> DONE when eval stage empties; DONE -> IDLE after one cycle. `start` with `num_clauses`==0: IDLE -> DONE directly, `all_sat`=1.
- Pipeline: stage A address issue; stage B memory data; gather mux registers `eval_*[i]` = `var_val/var_unassign[clause_rd_vars slot i]`, mask/pole copied; stage C classify using `eval_partial_sat`.
- Unmasked slots drive `eval_unassign`=0, `eval_val`=0.
- Classification of a valid stage-C clause with mask != 0: sat if `eval_partial_sat`; else count u = popcount(mask & unassign); u==0 -> conflict; u==1 -> unit; u>=2 -> undecided. mask==0: ignored (counts as satisfied).
- `all_sat` clears on first non-sat, non-empty clause.
- Unit: first in index order latched; `unit_var` = that slot's index, `unit_val` = ~pole of that slot. Later units do not overwrite.
- Conflict terminates early: stop issuing, discard stages A/B, go DONE. Conflict outranks unit; `unit_*` keep values latched earlier.
- `var_val`/`var_unassign` must stay stable while `busy`; not re-sampled.
- Result outputs cleared at accepted `start`, then held after `done` until next accepted `start`.

## Timing
- Reset (`reset_n`=0 at edge): state IDLE; `busy`, `done`, `clause_rd_en`, `all_sat`, `conflict`, `unit_found`, `unit_val`, all `eval_*`, `clause_rd_addr`, `conflict_idx`, `unit_var` = 0. Reset mid-scan aborts immediately, no `done`.
- `start` sampled at edge 0: `busy`=1 from cycle 1; address k driven in cycle k+1; eval vectors for k in cycle k+3; classified at end of cycle k+3.
- No conflict, N clauses: `done` high in cycle N+4; `busy` low from cycle N+5.
- Conflict at clause k: `conflict`, `conflict_idx` valid and `done` high in cycle k+4.
- N==0: `done` in cycle 1.

## Test plan
- N=3, all clauses have one true literal (var0 val=1 pole=0) -> `done` cycle 7, `all_sat`=1, `conflict`=0, `unit_found`=0.
- Clause 2 mask 00111, vars 1,2,3 assigned val=1 pole=1 -> `conflict`=1, `conflict_idx`=2, `done` cycle 6, no reads after addr 2's stage flush.
- Clause 0 mask 00011, var5 assigned false, var9 unassigned, pole slot1=1 -> `unit_found`=1, `unit_var`=9, `unit_val`=0, `all_sat`=0.
- Units at clauses 1 (var4) and 3 (var7) -> `unit_var`=4; then conflict at clause 5 -> `conflict`=1, `unit_var` still 4.
- `num_clauses`=0 -> `done` cycle 1, `all_sat`=1; `start` pulsed while busy -> ignored; mask-0 clause mid-scan -> `all_sat` unaffected.
- Assert `reset_n`=0 at cycle 3 of an 8-clause scan -> all outputs 0 next cycle, no `done`; new `start` completes normally.
